// File: rtl/onchip_memory_burst.sv
// Avalon-MM on-chip RAM slave with byte enables, incrementing read/write
// bursts, waitrequest flow control and a 1- or 2-cycle readdatavalid path.
module onchip_memory_burst #(
  parameter int    DATA_WIDTH   = 128,
  parameter int    ADDR_WIDTH   = 8,
  parameter int    DEPTH        = 256,
  parameter int    READ_LATENCY = 2,
  parameter int    MAX_BURST    = 8,
  parameter int    BURST_WIDTH  = 4,
  parameter string INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic [BURST_WIDTH-1:0]  burstcount,
  input  logic                    clken,
  input  logic                    reset_req,
  output logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid
);

  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_t;

  state_t                 state;
  logic [BURST_WIDTH-1:0] beats_left;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   en;
  logic                   wr_en;
  logic                   rd_issue;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [BURST_WIDTH-1:0] blen;

  logic                   vld_p0;
  logic [DATA_WIDTH-1:0]  data_p0;

  function automatic logic [BURST_WIDTH-1:0] sat_burst(input logic [BURST_WIDTH-1:0] bc);
    if (bc == '0)
      return BURST_WIDTH'(1);
    else if (int'(bc) > MAX_BURST)
      return BURST_WIDTH'(MAX_BURST);
    else
      return bc;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (int'(a) >= DEPTH - 1)
      return '0;
    else
      return a + ADDR_WIDTH'(1);
  endfunction

  assign en          = clken & ~reset_req;
  assign blen        = sat_burst(burstcount);
  assign waitrequest = ~en | (state == RBURST);

  always_comb begin
    wr_en    = 1'b0;
    rd_issue = 1'b0;
    wr_addr  = address;
    rd_addr  = address;
    case (state)
      IDLE: begin
        if (en && chipselect && write)
          wr_en = 1'b1;
        else if (en && chipselect && read)
          rd_issue = 1'b1;
      end
      WBURST: begin
        wr_addr = addr;
        if (en && chipselect && write)
          wr_en = 1'b1;
      end
      RBURST: begin
        rd_addr = addr;
        if (en)
          rd_issue = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      beats_left <= '0;
      addr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((wr_en || rd_issue) && blen > BURST_WIDTH'(1)) begin
            state      <= wr_en ? WBURST : RBURST;
            beats_left <= blen - BURST_WIDTH'(1);
            addr       <= next_addr(address);
          end
        end
        WBURST: begin
          if (wr_en) begin
            addr       <= next_addr(addr);
            beats_left <= beats_left - BURST_WIDTH'(1);
            if (beats_left == BURST_WIDTH'(1))
              state <= IDLE;
          end
        end
        RBURST: begin
          if (rd_issue) begin
            addr       <= next_addr(addr);
            beats_left <= beats_left - BURST_WIDTH'(1);
            if (beats_left == BURST_WIDTH'(1))
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (byteenable[b])
          mem[wr_addr][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
  end

  // Stage p0: synchronous array read
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (en) begin
      vld_p0 <= rd_issue;
      if (rd_issue)
        data_p0 <= mem[rd_addr];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  vld_p1;
      logic [DATA_WIDTH-1:0] data_p1;

      // Stage p1: output register
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end else if (en) begin
          vld_p1 <= vld_p0;
          if (vld_p0)
            data_p1 <= data_p0;
        end
      end

      assign readdatavalid = vld_p1;
      assign readdata      = data_p1;
    end else begin : g_lat1
      assign readdatavalid = vld_p0;
      assign readdata      = data_p0;
    end
  endgenerate

endmodule

// File: tb/tb_onchip_memory_burst.sv
// Directed bench for onchip_memory_burst: a READ_LATENCY=2 instance is the
// main target, a READ_LATENCY=1 instance shares its stimulus.
module tb_onchip_memory_burst;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [7:0]   address = '0;
    logic [15:0]  byteenable = '1;
    logic         chipselect = 1'b0;
    logic         read = 1'b0;
    logic         write = 1'b0;
    logic [127:0] writedata = '0;
    logic [3:0]   burstcount = 4'd1;
    logic         clken = 1'b1;
    logic         reset_req = 1'b0;

    logic         waitrequest, readdatavalid;
    logic [127:0] readdata;
    logic         wr1, rdv1;
    logic [127:0] rd1;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};

    always #5 clk = ~clk;

    onchip_memory_burst #(.READ_LATENCY(2)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .burstcount(burstcount), .clken(clken), .reset_req(reset_req),
        .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid)
    );

    onchip_memory_burst #(.READ_LATENCY(1)) dut_l1 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .burstcount(burstcount), .clken(clken), .reset_req(reset_req),
        .waitrequest(wr1), .readdata(rd1), .readdatavalid(rdv1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [127:0] d, input logic [15:0] be);
        address = a; writedata = d; byteenable = be; burstcount = 4'd1;
        chipselect = 1'b1; write = 1'b1;
        tick();
        chipselect = 1'b0; write = 1'b0; byteenable = '1;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [127:0] d);
        address = a; burstcount = 4'd1; chipselect = 1'b1; read = 1'b1;
        tick();
        chipselect = 1'b0; read = 1'b0;
        d = 'x;
        for (int i = 0; i < 6; i++) begin
            if (readdatavalid) begin
                d = readdata;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        tests_run++; if (waitrequest !== 1'b0) begin tests_failed++; $display("FAIL reset_waitrequest: got %b expected 0", waitrequest); end
        tests_run++; if (readdatavalid !== 1'b0) begin tests_failed++; $display("FAIL reset_rdv: got %b expected 0", readdatavalid); end
        tests_run++; if (readdata !== 128'h0) begin tests_failed++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
        tests_run++; if (rdv1 !== 1'b0 || rd1 !== 128'h0) begin tests_failed++; $display("FAIL reset_l1_out: got %b/%h expected 0/0", rdv1, rd1); end
        reset_n = 1'b1;
        tick();
        clken = 1'b0; #1;
        tests_run++; if (waitrequest !== 1'b1) begin tests_failed++; $display("FAIL idle_clken_low_wait: got %b expected 1", waitrequest); end
        clken = 1'b1; reset_req = 1'b1; #1;
        tests_run++; if (waitrequest !== 1'b1) begin tests_failed++; $display("FAIL idle_reset_req_wait: got %b expected 1", waitrequest); end
        reset_req = 1'b0;
        tick();
    endtask

    task automatic test_single_rw();
        do_write(8'h10, PAT_A5, '1);
        address = 8'h10; burstcount = 4'd1; chipselect = 1'b1; read = 1'b1;
        tick();
        chipselect = 1'b0; read = 1'b0;
        tests_run++; if (readdatavalid !== 1'b0) begin tests_failed++; $display("FAIL single_lat2_early: got %b expected 0", readdatavalid); end
        tests_run++; if (rdv1 !== 1'b1 || rd1 !== PAT_A5) begin tests_failed++; $display("FAIL single_lat1: got %b/%h expected 1/%h", rdv1, rd1, PAT_A5); end
        tick();
        tests_run++; if (readdatavalid !== 1'b1 || readdata !== PAT_A5) begin tests_failed++; $display("FAIL single_lat2: got %b/%h expected 1/%h", readdatavalid, readdata, PAT_A5); end
        tick();
        tests_run++; if (readdatavalid !== 1'b0) begin tests_failed++; $display("FAIL single_lat2_done: got %b expected 0", readdatavalid); end
    endtask

    task automatic test_byteenable();
        logic [127:0] d;
        do_write(8'h03, 128'h0, '1);
        do_write(8'h03, '1, 16'h0001);
        do_read(8'h03, d);
        tests_run++; if (d !== 128'hFF) begin tests_failed++; $display("FAIL byteenable_merge: got %h expected %h", d, 128'hFF); end
    endtask

    task automatic test_preload();
        int stalls = 0;
        chipselect = 1'b1; write = 1'b1; byteenable = '1; burstcount = 4'd1;
        for (int k = 0; k < 256; k++) begin
            address = 8'(k);
            writedata = 128'(k);
            #1;
            if (waitrequest) stalls++;
            tick();
        end
        chipselect = 1'b0; write = 1'b0;
        tests_run++; if (stalls != 0) begin tests_failed++; $display("FAIL preload_no_bubble: got %0d stalled cycles expected 0", stalls); end
    endtask

    task automatic test_read_burst_wrap();
        logic         exp_w [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic         exp_v [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [127:0] exp_d [6] = '{128'h0, 128'hFE, 128'hFF, 128'h00, 128'h01, 128'h0};
        address = 8'hFE; burstcount = 4'd4; chipselect = 1'b1; read = 1'b1;
        tick();
        chipselect = 1'b0; read = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tests_run++; if (waitrequest !== exp_w[i]) begin tests_failed++; $display("FAIL rburst_wait[%0d]: got %b expected %b", i, waitrequest, exp_w[i]); end
            tests_run++; if (readdatavalid !== exp_v[i]) begin tests_failed++; $display("FAIL rburst_valid[%0d]: got %b expected %b", i, readdatavalid, exp_v[i]); end
            if (exp_v[i]) begin
                tests_run++; if (readdata !== exp_d[i]) begin tests_failed++; $display("FAIL rburst_data[%0d]: got %h expected %h", i, readdata, exp_d[i]); end
            end
            tick();
        end
    endtask

    task automatic test_write_burst_gap();
        logic [127:0] d;
        logic [7:0]   ra [5] = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h50};
        logic [127:0] rx [5] = '{128'h1000, 128'h1001, 128'h1002, 128'h2000, 128'h50};
        address = 8'h08; burstcount = 4'd3; writedata = 128'h1000; byteenable = '1;
        chipselect = 1'b1; write = 1'b1;
        tick();
        tests_run++; if (waitrequest !== 1'b0) begin tests_failed++; $display("FAIL wburst_zero_wait: got %b expected 0", waitrequest); end
        address = 8'h50; burstcount = 4'd1; writedata = 128'h1001;
        tick();
        write = 1'b0;
        tick();
        write = 1'b1; writedata = 128'h1002;
        tick();
        address = 8'h0B; writedata = 128'h2000;
        tick();
        chipselect = 1'b0; write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_read(ra[i], d);
            tests_run++; if (d !== rx[i]) begin tests_failed++; $display("FAIL wburst_readback[%h]: got %h expected %h", ra[i], d, rx[i]); end
        end
    endtask

    task automatic test_back_to_back();
        address = 8'h60; burstcount = 4'd0; chipselect = 1'b1; read = 1'b1;
        tick();
        tests_run++; if (waitrequest !== 1'b0) begin tests_failed++; $display("FAIL b2b_burst0_single: got %b expected 0", waitrequest); end
        address = 8'h61; burstcount = 4'd1;
        tick();
        tests_run++; if (readdatavalid !== 1'b1 || readdata !== 128'h60) begin tests_failed++; $display("FAIL b2b_beat0: got %b/%h expected 1/60", readdatavalid, readdata); end
        address = 8'h62;
        tick();
        tests_run++; if (readdatavalid !== 1'b1 || readdata !== 128'h61) begin tests_failed++; $display("FAIL b2b_beat1: got %b/%h expected 1/61", readdatavalid, readdata); end
        chipselect = 1'b0; read = 1'b0;
        tick();
        tests_run++; if (readdatavalid !== 1'b1 || readdata !== 128'h62) begin tests_failed++; $display("FAIL b2b_beat2: got %b/%h expected 1/62", readdatavalid, readdata); end
        tick();
        tests_run++; if (readdatavalid !== 1'b0) begin tests_failed++; $display("FAIL b2b_done: got %b expected 0", readdatavalid); end
    endtask

    task automatic test_burst_sat();
        int nv = 0;
        int nw = 0;
        address = 8'h70; burstcount = 4'hF; chipselect = 1'b1; read = 1'b1;
        tick();
        chipselect = 1'b0; read = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (readdatavalid) nv++;
            if (waitrequest) nw++;
            tick();
        end
        tests_run++; if (nv != 8) begin tests_failed++; $display("FAIL burst_sat_beats: got %0d expected 8", nv); end
        tests_run++; if (nw != 7) begin tests_failed++; $display("FAIL burst_sat_wait: got %0d expected 7", nw); end
    endtask

    task automatic test_stall(input bit use_reset_req, input logic [7:0] base);
        logic [127:0] got [4];
        int  n = 0;
        int  first = -1;
        int  last = -1;
        bit  stall;
        address = base; burstcount = 4'd4; chipselect = 1'b1; read = 1'b1;
        tick();
        chipselect = 1'b0; read = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stall = (i == 1 || i == 2);
            if (use_reset_req) reset_req = stall;
            else clken = !stall;
            #1;
            if (i == 1) begin
                tests_run++; if (rdv1 !== 1'b1 || wr1 !== 1'b1) begin tests_failed++; $display("FAIL stall_hold[%0d]: got rdv %b wait %b expected 1 1", use_reset_req, rdv1, wr1); end
            end
            if (!stall && rdv1) begin
                if (n < 4) got[n] = rd1;
                if (first < 0) first = i;
                last = i;
                n++;
            end
            tick();
        end
        clken = 1'b1; reset_req = 1'b0;
        tests_run++; if (n != 4) begin tests_failed++; $display("FAIL stall_count[%0d]: got %0d expected 4", use_reset_req, n); end
        for (int j = 0; j < 4 && j < n; j++) begin
            tests_run++; if (got[j] !== 128'(int'(base) + j)) begin tests_failed++; $display("FAIL stall_data[%0d][%0d]: got %h expected %h", use_reset_req, j, got[j], 128'(int'(base) + j)); end
        end
        tests_run++; if (last - first != 5) begin tests_failed++; $display("FAIL stall_span[%0d]: got %0d expected 5", use_reset_req, last - first); end
    endtask

    task automatic test_reset_midburst();
        logic [127:0] d;
        int nv = 0;
        address = 8'h40; burstcount = 4'd8; chipselect = 1'b1; read = 1'b1;
        tick();
        chipselect = 1'b0; read = 1'b0; reset_n = 1'b0;
        tick();
        tests_run++; if (readdatavalid !== 1'b0 || rdv1 !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid: got %b/%b expected 0/0", readdatavalid, rdv1); end
        tests_run++; if (waitrequest !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_idle: got %b expected 0", waitrequest); end
        tests_run++; if (readdata !== 128'h0) begin tests_failed++; $display("FAIL rst_mid_readdata: got %h expected 0", readdata); end
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (readdatavalid || rdv1) nv++;
        end
        tests_run++; if (nv != 0) begin tests_failed++; $display("FAIL rst_mid_no_beats: got %0d expected 0", nv); end
        do_read(8'h40, d);
        tests_run++; if (d !== 128'h40) begin tests_failed++; $display("FAIL rst_mid_mem40: got %h expected 40", d); end
        do_read(8'h0B, d);
        tests_run++; if (d !== 128'h2000) begin tests_failed++; $display("FAIL rst_mid_mem0b: got %h expected 2000", d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_rw();
        test_byteenable();
        test_preload();
        test_read_burst_wrap();
        test_write_burst_gap();
        test_back_to_back();
        test_burst_sat();
        test_stall(1'b0, 8'h20);
        test_stall(1'b1, 8'h30);
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
